q2b_stim_chk: RTL and testbench
===============================

Name: q2b_stim_chk

Overview:
- Clocked stimulus sequencer and response checker that sits directly upstream and downstream of the 4-input combinational q2b block.
- Drives a,b,c,d through all 16 combinations in binary order, holding each vector for HOLD cycles.
- Samples q2b's f and g outputs and compares them against truth-table parameters.
- Reports the mismatch count, the first failing vector, and pass/done status, so the q2b check is self-checking in hardware rather than by waveform inspection.

Parameters:
- HOLD, 20, clock cycles each vector is held; legal range 1..255.
- F_TRUTH, 16'h6996, expected f; bit i is the f value for vector i, where i = {a,b,c,d} and a is the MSB.
- G_TRUTH, 16'h8000, expected g; same bit indexing as F_TRUTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a sweep.
- a  out  1  stimulus bit 3 (MSB of vector index).
- b  out  1  stimulus bit 2.
- c  out  1  stimulus bit 1.
- d  out  1  stimulus bit 0.
- f_in  in  1  q2b output f.
- g_in  in  1  q2b output g.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; sticky until next start or rst.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  5  number of vectors (0..16) where f or g mismatched.
- first_err_valid  out  1  at least one mismatch recorded this sweep.
- first_err_vec  out  4  index of the first mismatching vector.

Behaviour:
- Reset (rst=1 at clock edge):
  - State goes to IDLE.
  - Vector index idx=0, hold counter hc=0.
  - Outputs a/b/c/d=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0.
  - rst has priority over start and over every state.
  - rst mid-sweep aborts the sweep immediately; no partial results are retained.
- Stimulus: {a,b,c,d} = idx, registered. Value is 0 whenever the state is not DRIVE.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE:
    - start=1 -> DRIVE.
    - On the same edge: idx=0, hc=0, err_cnt=0, first_err_valid=0, first_err_vec=0.
  - DRIVE:
    - busy=1.
    - hc increments each cycle.
    - When hc==HOLD-1 (the last cycle of the vector), f_in/g_in are sampled and compared to F_TRUTH[idx] and G_TRUTH[idx].
    - On that sample cycle:
      - Any mismatch increments err_cnt by 1 (one count per vector, even if both f and g differ).
      - If this is the first mismatch: first_err_valid=1 and first_err_vec=idx.
      - hc returns to 0.
      - If idx==15 -> DONE; otherwise idx increments.
    - start is ignored in DRIVE.
  - DONE:
    - busy=0, done=1, pass=(err_cnt==0).
    - Results hold until the next event.
    - start=1 -> DRIVE with the same clearing as from IDLE; done and pass drop on that edge.
- Timing:
  - start is sampled at edge 0.
  - Vector 0 is present from edge 0 to edge HOLD.
  - Vector i is present for cycles [i*HOLD, (i+1)*HOLD).
  - Last sample occurs at cycle 16*HOLD-1.
  - done=1 from edge 16*HOLD onward.
  - Total sweep length is 16*HOLD cycles.
- HOLD=1: each vector lasts one cycle and is sampled in that same cycle. q2b is combinational, so its outputs settle within the cycle.
- err_cnt saturates naturally at 16; it is 5 bits wide, so it never wraps.
- idx wraps only by the DRIVE -> DONE transition; it never rolls from 15 back to 0 while in DRIVE.
- start held high continuously: one sweep per DONE visit, i.e. back-to-back sweeps separated by a single DONE cycle.

Test Plan:
- Golden model returning F_TRUTH/G_TRUTH bits, HOLD=20, single start pulse -> a/b/c/d step 0000..1111 every 20 cycles; done=1 at cycle 320; err_cnt=0, pass=1, first_err_valid=0.
- f_in tied 0 with default F_TRUTH=16'h6996 -> err_cnt=8, first_err_vec=4'd1, first_err_valid=1, pass=0.
- f_in and g_in swapped relative to the golden model -> mismatches on vectors 1,2,4,7,8,11,13,14 (f) and 15 (g); err_cnt=9, first_err_vec=1.
- rst asserted for one cycle while idx=7 -> next cycle a/b/c/d=0, busy=0, err_cnt=0, done=0; a subsequent start runs a full 320-cycle sweep.
- start pulsed at idx=3 during DRIVE -> no restart; idx continues 4,5,...; done still at cycle 320.
- HOLD=1, golden model -> new vector every cycle; done=1 at cycle 16, pass=1. A start while done=1 clears done on the next cycle and repeats the sweep.

Source files
------------

// File: rtl/q2b_stim_chk.sv
// q2b_stim_chk: clocked stimulus sequencer and response checker for the
// 4-input combinational q2b block. Sweeps {a,b,c,d} through 0..15, holds each
// vector for HOLD cycles, and compares f/g against truth-table parameters on
// the last cycle of each vector. Reports mismatch count, first failing vector
// and pass/done status.
module q2b_stim_chk #(
    parameter int unsigned HOLD    = 20,
    parameter logic [15:0] F_TRUTH = 16'h6996,
    parameter logic [15:0] G_TRUTH = 16'h8000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f_in,
    input  logic       g_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       first_err_valid,
    output logic [3:0] first_err_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    // Hold-counter value on the final cycle of a vector; HOLD=1 gives 0, so
    // every DRIVE cycle is a sample cycle.
    localparam logic [7:0] HC_LAST = 8'(HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [7:0] hc;
    logic       sample;
    logic       launch;
    logic       mismatch;

    // One count per vector: f and g both wrong still counts once.
    function automatic logic vec_mismatch(input logic [3:0] v, input logic f, input logic g);
        return (f != F_TRUTH[v]) || (g != G_TRUTH[v]);
    endfunction

    assign sample   = (state == DRIVE) && (hc == HC_LAST);
    assign launch   = start && (state != DRIVE);
    assign mismatch = vec_mismatch(idx, f_in, g_in);

    // Stimulus is the registered vector index, forced to zero outside DRIVE.
    assign {a, b, c, d} = (state == DRIVE) ? idx : 4'd0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (sample && (idx == 4'hF)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                pass = (err_cnt == 5'd0);
                if (start) begin
                    state_nxt = DRIVE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector index, hold counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= 4'd0;
            hc              <= 8'd0;
            err_cnt         <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
        end else if (launch) begin
            idx             <= 4'd0;
            hc              <= 8'd0;
            err_cnt         <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
        end else if (state == DRIVE) begin
            if (sample) begin
                hc <= 8'd0;
                // After vector 15 this wraps to 0 on the same edge that leaves DRIVE.
                idx <= idx + 4'd1;
                if (mismatch) begin
                    err_cnt <= err_cnt + 5'd1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= idx;
                    end
                end
            end else begin
                hc <= hc + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_q2b_stim_chk.sv
// Testbench for q2b_stim_chk: one instance with HOLD=20 fed by a q2b model
// with selectable faults, and one with HOLD=1 fed by the fault-free model.
module tb_q2b_stim_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       a0, b0, c0, d0, a1, b1, c1, d1;
    logic       f0, g0, f1, g1;
    logic       busy0, done0, pass0, fev0, busy1, done1, pass1, fev1;
    logic [4:0] err0, err1;
    logic [3:0] fvec0, fvec1;
    int         mode;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    q2b_stim_chk #(.HOLD(20), .F_TRUTH(16'h6996), .G_TRUTH(16'h8000)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .f_in(f0), .g_in(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_valid(fev0), .first_err_vec(fvec0)
    );

    q2b_stim_chk #(.HOLD(1), .F_TRUTH(16'h6996), .G_TRUTH(16'h8000)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .f_in(f1), .g_in(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fev1), .first_err_vec(fvec1)
    );

    // q2b model: f is odd parity, g is the AND of all four inputs.
    // mode 0 golden, 1 f stuck 0, 2 f/g swapped, 3 g stuck 1, 4 f inverted.
    always_comb begin
        logic pf, pg;
        pf = a0 ^ b0 ^ c0 ^ d0;
        pg = a0 & b0 & c0 & d0;
        f0 = pf;
        g0 = pg;
        case (mode)
            1: f0 = 1'b0;
            2: begin f0 = pg; g0 = pf; end
            3: g0 = 1'b1;
            4: f0 = ~pf;
            default: ;
        endcase
        f1 = a1 ^ b1 ^ c1 ^ d1;
        g1 = a1 & b1 & c1 & d1;
    end

    typedef struct {
        int         mode;
        int         restart_at;
        logic [4:0] err;
        logic       fev;
        logic [3:0] fvec;
        logic       pass;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full HOLD=20 sweep on dut0; start is sampled at edge 0, done expected at edge 320.
    task automatic sweep0(input vec_t v);
        int bad;
        bad  = 0;
        mode = v.mode;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_clr_err", err0, 0);
        check("start_clr_fev", fev0, 0);
        check("start_clr_done", done0, 0);
        check("start_busy", busy0, 1);
        for (int k = 0; k < 320; k++) begin
            if (k > 0) tick();
            if ({a0, b0, c0, d0} != 4'(k / 20) || busy0 !== 1'b1 || done0 !== 1'b0) bad++;
            start0 = (k == v.restart_at) ? 1'b1 : 1'b0;
        end
        start0 = 1'b0;
        check("stim_seq_bad_cycles", bad, 0);
        tick();
        check("done_at_320", done0, 1);
        check("busy_off", busy0, 0);
        check("stim_zero_done", {a0, b0, c0, d0}, 0);
        check("err_cnt", err0, v.err);
        check("first_err_valid", fev0, v.fev);
        check("first_err_vec", fvec0, v.fvec);
        check("pass", pass0, v.pass);
    endtask

    initial begin
        int bad;
        vec_t golden;
        tbl[0] = '{0, -1, 5'd0,  1'b0, 4'd0, 1'b1};
        tbl[1] = '{1, -1, 5'd8,  1'b1, 4'd1, 1'b0};
        tbl[2] = '{2, -1, 5'd9,  1'b1, 4'd1, 1'b0};
        tbl[3] = '{3, -1, 5'd15, 1'b1, 4'd0, 1'b0};
        tbl[4] = '{4, -1, 5'd16, 1'b1, 4'd0, 1'b0};
        tbl[5] = '{0, 65, 5'd0,  1'b0, 4'd0, 1'b1};
        golden = tbl[0];

        mode = 0; rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_stim", {a0, b0, c0, d0}, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fev", fev0, 0);
        check("rst_fvec", fvec0, 0);
        check("rst_done_h1", done1, 0);

        for (int i = 0; i < 6; i++) sweep0(tbl[i]);

        // Reset while vector 7 is being driven aborts and clears everything.
        mode = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (145) tick();
        check("mid_idx7", {a0, b0, c0, d0}, 7);
        check("mid_err", err0, 3);
        check("mid_fvec", fvec0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_stim", {a0, b0, c0, d0}, 0);
        check("abort_busy", busy0, 0);
        check("abort_err", err0, 0);
        check("abort_done", done0, 0);
        check("abort_fev", fev0, 0);
        tick();
        check("abort_stays_idle", busy0, 0);
        sweep0(golden);

        // HOLD=1: a new vector each cycle, done at edge 16.
        bad = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            if ({a1, b1, c1, d1} != 4'(k) || busy1 !== 1'b1) bad++;
        end
        check("h1_stim_seq", bad, 0);
        check("h1_not_done_15", done1, 0);
        tick();
        check("h1_done_16", done1, 1);
        check("h1_pass", pass1, 1);
        check("h1_err", err1, 0);

        // start held high: back-to-back sweeps with a single DONE cycle between.
        start1 = 1'b1;
        tick();
        check("h1_restart_done_drop", done1, 0);
        check("h1_restart_busy", busy1, 1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            if ({a1, b1, c1, d1} != 4'(k)) bad++;
        end
        check("h1_second_seq", bad, 0);
        tick();
        check("h1_second_done", done1, 1);
        tick();
        check("h1_third_start", done1, 0);
        check("h1_third_busy", busy1, 1);
        start1 = 1'b0;
        repeat (15) tick();
        check("h1_third_last", done1, 0);
        tick();
        check("h1_third_done", done1, 1);
        check("h1_third_pass", pass1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
